// File: rtl/blit_pixwrite.sv
// Pixel write engine: clips incoming pixels, computes byte addresses, coalesces
// same-word pixels into a one-word buffer and issues strobed 32-bit writes.
module blit_pixwrite (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic signed [15:0] in_x,
  input  logic signed [15:0] in_y,
  input  logic        [7:0]  in_color,
  input  logic               in_last,
  output logic               stall,
  input  logic        [31:0] dest_base,
  input  logic        [15:0] dest_pitch,
  input  logic signed [15:0] clip_x1,
  input  logic signed [15:0] clip_y1,
  input  logic signed [15:0] clip_x2,
  input  logic signed [15:0] clip_y2,
  output logic               mem_valid,
  output logic        [31:0] mem_addr,
  output logic        [31:0] mem_wdata,
  output logic        [3:0]  mem_wstrb,
  input  logic               mem_ready,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_s1_valid;
  logic        r_s1_keep;
  logic        r_s1_last;
  logic [31:0] r_s1_addr;
  logic [7:0]  r_s1_color;
  logic        r_buf_valid;
  logic [29:0] r_buf_waddr;
  logic [31:0] r_buf_data;
  logic [3:0]  r_buf_strb;
  logic        r_mem_valid;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic        r_done;

  logic        w_out_free;
  logic        w_stall;
  logic        w_accept;
  logic        w_keep;
  logic [31:0] w_x32;
  logic [31:0] w_y32;
  logic [31:0] w_pitch32;
  logic [31:0] w_addr;
  logic        w_s1_adv;
  logic        w_s1_wr;
  logic        w_same;
  logic [1:0]  w_lane;

  // Place one byte into the selected little-endian lane of a word.
  function automatic logic [31:0] f_lane_merge(input logic [31:0] old_data,
                                               input logic [7:0]  color,
                                               input logic [1:0]  lane);
    logic [31:0] res;
    res = old_data;
    case (lane)
      2'd0:    res[7:0]   = color;
      2'd1:    res[15:8]  = color;
      2'd2:    res[23:16] = color;
      2'd3:    res[31:24] = color;
      default: res        = old_data;
    endcase
    return res;
  endfunction

  assign w_out_free = !r_mem_valid || mem_ready;
  assign w_stall    = (r_mem_valid && !mem_ready) ||
                      (r_state == ST_FLUSH) || (r_state == ST_DRAIN);
  assign w_accept   = in_valid && !w_stall;
  assign w_keep     = (clip_x1 <= in_x) && (in_x < clip_x2) &&
                      (clip_y1 <= in_y) && (in_y < clip_y2);

  // Coordinates are sign-extended so the modulo-2^32 sum wraps consistently.
  assign w_x32      = {{16{in_x[15]}}, in_x};
  assign w_y32      = {{16{in_y[15]}}, in_y};
  assign w_pitch32  = {16'd0, dest_pitch};
  assign w_addr     = dest_base + (w_y32 * w_pitch32) + w_x32;

  assign w_s1_adv   = r_s1_valid && !w_stall;
  assign w_s1_wr    = w_s1_adv && r_s1_keep;
  assign w_lane     = r_s1_addr[1:0];
  assign w_same     = r_buf_valid && (r_buf_waddr == r_s1_addr[31:2]);

  // Pipeline, coalesce buffer, output register and sequencing FSM.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_s1_valid  <= 1'b0;
      r_s1_keep   <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_addr   <= 32'd0;
      r_s1_color  <= 8'd0;
      r_buf_valid <= 1'b0;
      r_buf_waddr <= 30'd0;
      r_buf_data  <= 32'd0;
      r_buf_strb  <= 4'd0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_wstrb <= 4'd0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_mem_valid && mem_ready) begin
        r_mem_valid <= 1'b0;
      end

      if (!w_stall) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_addr  <= w_addr;
          r_s1_color <= in_color;
          r_s1_keep  <= w_keep;
          r_s1_last  <= in_last;
        end
      end

      if (w_s1_wr) begin
        if (w_same) begin
          r_buf_data <= f_lane_merge(r_buf_data, r_s1_color, w_lane);
          r_buf_strb <= r_buf_strb | (4'b0001 << w_lane);
        end else begin
          if (r_buf_valid) begin
            r_mem_valid <= 1'b1;
            r_mem_addr  <= {r_buf_waddr, 2'b00};
            r_mem_wdata <= r_buf_data;
            r_mem_wstrb <= r_buf_strb;
          end
          r_buf_valid <= 1'b1;
          r_buf_waddr <= r_s1_addr[31:2];
          r_buf_data  <= f_lane_merge(32'd0, r_s1_color, w_lane);
          r_buf_strb  <= 4'b0001 << w_lane;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (w_s1_adv && r_s1_last) begin
            r_state <= ST_FLUSH;
          end else if (w_accept || r_s1_valid) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_s1_adv && r_s1_last) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (w_out_free) begin
            if (r_buf_valid) begin
              r_mem_valid <= 1'b1;
              r_mem_addr  <= {r_buf_waddr, 2'b00};
              r_mem_wdata <= r_buf_data;
              r_mem_wstrb <= r_buf_strb;
              r_buf_valid <= 1'b0;
            end
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_out_free) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign stall     = w_stall;
  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign done      = r_done;
  assign busy      = (r_state != ST_IDLE) || r_s1_valid || r_buf_valid;

endmodule

// File: tb/tb_blit_pixwrite.sv
// Directed bench for blit_pixwrite: single-pixel vector table plus multi-pixel
// sequences for coalescing, clipping, backpressure and mid-operation reset.
module tb_blit_pixwrite;

  logic               clock = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [15:0] in_x, in_y;
  logic        [7:0]  in_color;
  logic               in_last;
  logic               stall;
  logic        [31:0] dest_base;
  logic        [15:0] dest_pitch;
  logic signed [15:0] clip_x1, clip_y1, clip_x2, clip_y2;
  logic               mem_valid;
  logic        [31:0] mem_addr, mem_wdata;
  logic        [3:0]  mem_wstrb;
  logic               mem_ready;
  logic               busy, done;

  blit_pixwrite dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .in_color(in_color), .in_last(in_last), .stall(stall), .dest_base(dest_base),
    .dest_pitch(dest_pitch), .clip_x1(clip_x1), .clip_y1(clip_y1),
    .clip_x2(clip_x2), .clip_y2(clip_y2), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  typedef struct {
    logic signed [15:0] x, y;
    logic [7:0]         c;
    logic [31:0]        base;
    logic [15:0]        pitch;
    logic signed [15:0] cx1, cy1, cx2, cy2;
    logic               exp_wr;
    logic [31:0]        exp_addr, exp_data;
    logic [3:0]         exp_strb;
  } vec_t;

  wr_t wr_q[$];
  int  mv_cycles = 0;
  int  done_cnt  = 0;
  int  total = 0;
  int  bad   = 0;
  int  op_wr0, op_mv0, op_done0;
  vec_t vecs[12];

  // Observe completed writes, valid cycles and done pulses away from the edge.
  always @(negedge clock) begin
    if (reset) begin
      if (mem_valid) mv_cycles++;
      if (mem_valid && mem_ready) wr_q.push_back('{mem_addr, mem_wdata, mem_wstrb});
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input logic [31:0] b, input logic [15:0] p,
                         input logic signed [15:0] x1, y1, x2, y2);
    dest_base = b; dest_pitch = p;
    clip_x1 = x1; clip_y1 = y1; clip_x2 = x2; clip_y2 = y2;
  endtask

  task automatic send_px(input logic signed [15:0] x, y, input logic [7:0] c, input logic last);
    int g;
    @(negedge clock);
    in_x = x; in_y = y; in_color = c; in_last = last; in_valid = 1'b1;
    #1;
    g = 0;
    while (stall && g < 200) begin
      @(negedge clock); #1; g++;
    end
    chk("send_accept", 32'(stall), 32'd0);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic begin_op();
    op_wr0   = wr_q.size();
    op_mv0   = mv_cycles;
    op_done0 = done_cnt;
  endtask

  task automatic end_op(input string name);
    int g;
    g = 0;
    while (done_cnt == op_done0 && g < 300) begin
      @(negedge clock); #1; g++;
    end
    repeat (3) @(negedge clock);
    #1;
    chk({name, "_done"}, 32'(done_cnt - op_done0), 32'd1);
    chk({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_wr(input string name, input int idx, input wr_t exp);
    if (wr_q.size() > op_wr0 + idx) begin
      chk({name, "_addr"}, wr_q[op_wr0 + idx].addr, exp.addr);
      chk({name, "_data"}, wr_q[op_wr0 + idx].data, exp.data);
      chk({name, "_strb"}, 32'(wr_q[op_wr0 + idx].strb), 32'(exp.strb));
    end else begin
      chk({name, "_present"}, 32'd0, 32'd1);
    end
  endtask

  function automatic vec_t mkv(input logic signed [15:0] x, y, input logic [7:0] c,
                               input logic [31:0] b, input logic [15:0] p,
                               input logic signed [15:0] x1, y1, x2, y2,
                               input logic w, input logic [31:0] a, d, input logic [3:0] s);
    vec_t v;
    v.x = x; v.y = y; v.c = c; v.base = b; v.pitch = p;
    v.cx1 = x1; v.cy1 = y1; v.cx2 = x2; v.cy2 = y2;
    v.exp_wr = w; v.exp_addr = a; v.exp_data = d; v.exp_strb = s;
    return v;
  endfunction

  initial begin
    int nw;
    int dsnap, wsnap;
    vecs[0]  = mkv(16'sd0,   16'sd0,   8'hAA, 32'h0,        16'd320,  16'sd0,  16'sd0,  16'sd320, 16'sd240, 1'b1, 32'h0,     32'h000000AA, 4'h1);
    vecs[1]  = mkv(16'sd3,   16'sd1,   8'h5C, 32'h1000,     16'd320,  16'sd0,  16'sd0,  16'sd320, 16'sd240, 1'b1, 32'h1140,  32'h5C000000, 4'h8);
    vecs[2]  = mkv(16'sd319, 16'sd239, 8'h01, 32'h0,        16'd320,  16'sd0,  16'sd0,  16'sd320, 16'sd240, 1'b1, 32'h12BFC, 32'h01000000, 4'h8);
    vecs[3]  = mkv(16'sd320, 16'sd0,   8'h12, 32'h0,        16'd320,  16'sd0,  16'sd0,  16'sd320, 16'sd240, 1'b0, 32'h0,     32'h0,        4'h0);
    vecs[4]  = mkv(16'sd0,   16'sd240, 8'h34, 32'h0,        16'd320,  16'sd0,  16'sd0,  16'sd320, 16'sd240, 1'b0, 32'h0,     32'h0,        4'h0);
    vecs[5]  = mkv(-16'sd1,  16'sd5,   8'h56, 32'h0,        16'd320,  16'sd0,  16'sd0,  16'sd320, 16'sd240, 1'b0, 32'h0,     32'h0,        4'h0);
    vecs[6]  = mkv(16'sd2,   16'sd3,   8'h3E, 32'h2000,     16'd64,   -16'sd4, -16'sd4, 16'sd8,   16'sd8,   1'b1, 32'h20C0,  32'h003E0000, 4'h4);
    vecs[7]  = mkv(16'sd8,   16'sd3,   8'h3F, 32'h2000,     16'd64,   -16'sd4, -16'sd4, 16'sd8,   16'sd8,   1'b0, 32'h0,     32'h0,        4'h0);
    vecs[8]  = mkv(-16'sd5,  16'sd0,   8'h40, 32'h2000,     16'd64,   -16'sd4, -16'sd4, 16'sd8,   16'sd8,   1'b0, 32'h0,     32'h0,        4'h0);
    vecs[9]  = mkv(16'sd7,   16'sd7,   8'h9D, 32'h2000,     16'd64,   -16'sd4, -16'sd4, 16'sd8,   16'sd8,   1'b1, 32'h21C4,  32'h9D000000, 4'h8);
    vecs[10] = mkv(16'sd1,   16'sh7FFE, 8'hC3, 32'h80030000, 16'hFFFF, 16'sd0, 16'sd0,  16'sh7FFF, 16'sh7FFF, 1'b1, 32'h8000, 32'hC3000000, 4'h8);
    vecs[11] = mkv(16'sd1,   16'sd1,   8'h42, 32'h0,        16'd320,  16'sd0,  16'sd0,  16'sd320, 16'sd240, 1'b1, 32'h140,   32'h00004200, 4'h2);

    reset = 1'b0; in_valid = 1'b0; in_x = 16'sd0; in_y = 16'sd0; in_color = 8'd0;
    in_last = 1'b0; mem_ready = 1'b1;
    set_cfg(32'h0, 16'd320, 16'sd0, 16'sd0, 16'sd320, 16'sd240);
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clock); #1 reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      set_cfg(vecs[i].base, vecs[i].pitch, vecs[i].cx1, vecs[i].cy1, vecs[i].cx2, vecs[i].cy2);
      begin_op();
      send_px(vecs[i].x, vecs[i].y, vecs[i].c, 1'b1);
      end_op($sformatf("vec%0d", i));
      nw = wr_q.size() - op_wr0;
      chk($sformatf("vec%0d_nwr", i), 32'(nw), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr)
        chk_wr($sformatf("vec%0d", i), 0, '{vecs[i].exp_addr, vecs[i].exp_data, vecs[i].exp_strb});
    end

    // Four pixels coalesce into one full word.
    set_cfg(32'h1000, 16'd320, 16'sd0, 16'sd0, 16'sd320, 16'sd240);
    begin_op();
    send_px(16'sd4, 16'sd2, 8'd11, 1'b0);
    send_px(16'sd5, 16'sd2, 8'd22, 1'b0);
    send_px(16'sd6, 16'sd2, 8'd33, 1'b0);
    send_px(16'sd7, 16'sd2, 8'd44, 1'b1);
    end_op("full");
    chk("full_nwr", 32'(wr_q.size() - op_wr0), 32'd1);
    chk_wr("full", 0, '{32'h1284, 32'h2C21160B, 4'hF});

    // Two pixels in different words produce two ordered writes.
    set_cfg(32'h0, 16'd320, 16'sd0, 16'sd0, 16'sd320, 16'sd240);
    begin_op();
    send_px(16'sd5, 16'sd0, 8'h55, 1'b0);
    send_px(16'sd9, 16'sd0, 8'h99, 1'b1);
    end_op("two");
    chk("two_nwr", 32'(wr_q.size() - op_wr0), 32'd2);
    chk_wr("two0", 0, '{32'h4, 32'h00005500, 4'h2});
    chk_wr("two1", 1, '{32'h8, 32'h00009900, 4'h2});

    // All pixels clipped: no write cycles, single done.
    begin_op();
    send_px(-16'sd1, 16'sd0, 8'h01, 1'b0);
    send_px(16'sd320, 16'sd0, 8'h02, 1'b1);
    end_op("clip");
    chk("clip_mv_cycles", 32'(mv_cycles - op_mv0), 32'd0);

    // Same lane written twice: later color wins, one write.
    begin_op();
    send_px(16'sd8, 16'sd0, 8'h11, 1'b0);
    send_px(16'sd8, 16'sd0, 8'h22, 1'b1);
    end_op("lane");
    chk("lane_nwr", 32'(wr_q.size() - op_wr0), 32'd1);
    chk_wr("lane", 0, '{32'h8, 32'h00000022, 4'h1});

    // Backpressure: five cycles of mem_ready=0 with a write pending.
    @(posedge clock); #1 mem_ready = 1'b0;
    begin_op();
    fork
      begin
        send_px(16'sd0, 16'sd0, 8'h10, 1'b0);
        send_px(16'sd4, 16'sd0, 8'h20, 1'b0);
        send_px(16'sd8, 16'sd0, 8'h30, 1'b1);
      end
      begin
        int g;
        g = 0;
        do begin @(negedge clock); #1; g++; end while (!mem_valid && g < 50);
        chk("bp_seen", 32'(mem_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
          chk($sformatf("bp_stall%0d", k), 32'(stall), 32'd1);
          chk($sformatf("bp_addr%0d", k), mem_addr, 32'h0);
          chk($sformatf("bp_data%0d", k), mem_wdata, 32'h00000010);
          chk($sformatf("bp_strb%0d", k), 32'(mem_wstrb), 32'h1);
          @(negedge clock); #1;
        end
        @(posedge clock); #1 mem_ready = 1'b1;
      end
    join
    end_op("bp");
    chk("bp_nwr", 32'(wr_q.size() - op_wr0), 32'd3);
    chk_wr("bp0", 0, '{32'h0, 32'h00000010, 4'h1});
    chk_wr("bp1", 1, '{32'h4, 32'h00000020, 4'h1});
    chk_wr("bp2", 2, '{32'h8, 32'h00000030, 4'h1});

    // Reset while draining with a write held: write is abandoned, no done.
    @(posedge clock); #1 mem_ready = 1'b0;
    send_px(16'sd0, 16'sd0, 8'h5A, 1'b1);
    repeat (4) @(negedge clock);
    #1;
    chk("rd_pre_valid", 32'(mem_valid), 32'd1);
    chk("rd_pre_stall", 32'(stall), 32'd1);
    dsnap = done_cnt;
    wsnap = wr_q.size();
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock);
    @(negedge clock); #1;
    chk("rd_valid", 32'(mem_valid), 32'd0);
    chk("rd_busy", 32'(busy), 32'd0);
    chk("rd_stall", 32'(stall), 32'd0);
    chk("rd_wstrb", 32'(mem_wstrb), 32'd0);
    @(posedge clock); #1 begin reset = 1'b1; mem_ready = 1'b1; end
    repeat (10) @(negedge clock);
    #1;
    chk("rd_no_done", 32'(done_cnt - dsnap), 32'd0);
    chk("rd_no_write", 32'(wr_q.size() - wsnap), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
